spi_axis_if_v2: RTL and testbench
=================================

Name: spi_axis_if_v2

Overview:
- Parametrised successor SPI master between an AXIS byte source (MOSI) and an AXIS byte sink (MISO).
- SCK is generated by a programmable divider from `clk`; no gated or BUFG clocks.
- Adds runtime SPI mode (CPOL/CPHA), 1/2/4-lane full-duplex shifting, multiple chip selects, and clean SCK stall on sink back-pressure.
- Sits between the register/FIFO fabric and the chip SPI pins, as the drop-in next generation of the current SPI AXIS interface.

Parameters:
- LANES, 1, data lanes per direction (1, 2 or 4); bits per SCK period = LANES; SCK periods per byte = 8/LANES.
- MSB_FIRST, 0, 1 = bit 7 leaves/arrives first; 0 = bit 0 first. With LANES>1, lane 0 carries the lowest-index bit of each group.
- DIV_W, 8, width of clk_div.
- N_CS, 1, number of chip-select outputs.

Ports:
- clk  in  1  system clock; all logic on posedge.
- resn  in  1  asynchronous active-low reset.
- enable  in  1  keep frame open; send 0x00 dummy bytes while the source is empty.
- clk_div  in  DIV_W  SCK half-period = clk_div+1 clk cycles.
- cpol  in  1  SCK idle level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- cs_sel  in  $clog2(N_CS) (min 1)  selected chip select.
- s_axis_tdata  in  8  byte to transmit.
- s_axis_tvalid  in  1  source valid.
- s_axis_tready  out  1  byte accepted this cycle.
- m_axis_tdata  out  8  received byte.
- m_axis_tvalid  out  1  received byte valid.
- m_axis_tready  in  1  sink ready.
- spi_csn  out  N_CS  active-low chip selects.
- spi_clk  out  1  SCK.
- spi_mosi  out  LANES  MOSI lanes.
- spi_miso  in  LANES  MISO lanes.
- busy  out  1  FSM not in IDLE.
- frame_bytes  out  16  bytes completed in current frame; saturates at 0xFFFF.

Behaviour:
- Reset values: spi_csn all 1, spi_clk 0, spi_mosi 0, s_axis_tready 0, m_axis_tvalid 0, m_axis_tdata 0, busy 0, frame_bytes 0. Reset asserted mid-frame aborts immediately; the partial RX byte is discarded.
- Latched config: cpol, cpha, clk_div and cs_sel are latched on IDLE->CS_SETUP. Changes mid-frame have no effect.
- Idle SCK: spi_clk = latched cpol whenever not in SHIFT.
- FSM states: IDLE, CS_SETUP, LOAD, SHIFT, STALL, CS_HOLD, CS_GAP.
- IDLE: go to CS_SETUP when s_axis_tvalid or enable. Selected csn goes low the next cycle.
- CS_SETUP: wait one half-period, then LOAD.
- LOAD (single cycle, byte boundary):
  - if s_axis_tvalid: s_axis_tready=1 (combinational, this cycle only), shift reg <= tdata, go SHIFT;
  - else if enable: shift reg <= 0x00, go SHIFT;
  - else go CS_HOLD.
- SHIFT: sck_gen produces leading/trailing strobes every half-period.
  - cpha=0: first bit group is on MOSI from entry to SHIFT; sample on leading edge, shift out on trailing edge.
  - cpha=1: shift out on leading edge, sample on trailing edge.
  - After 8/LANES sample edges and the final trailing edge, the RX byte is pushed to m_axis and frame_bytes increments.
- RX push: if m_axis_tvalid is already 1 and tready is 0, go STALL with the byte held internally. Otherwise set m_axis_tvalid/tdata the next cycle and go LOAD.
- m_axis_tvalid stays high until tready; tdata is stable while valid.
- STALL: SCK holds idle level, no edges. Leave when m_axis handshake completes, then push the held byte and go LOAD. Bytes are never dropped.
- Simultaneous tready and a new push in the same cycle: the new byte is loaded and valid stays 1.
- CS_HOLD: wait one half-period with SCK idle, then raise csn and go CS_GAP.
- CS_GAP: wait one half-period with csn high, then IDLE; frame_bytes clears on the IDLE->CS_SETUP transition.
- sck_gen divider: counter counts 0..clk_div, strobe at terminal count, counter reset on entry to SHIFT. clk_div=0 gives SCK = clk/2.
- Non-selected csn bits are always 1.

Decomposition:
- Package spi_pkg: byte_t; spi_state_e enum; function bits_per_byte(LANES) returning 8/LANES.
- Sub-module spi_sck_gen: divider counter, lead/trail strobes, SCK register with cpol.
- Elaboration error if LANES is not in {1,2,4}.

Test Plan:
- Mode 0, clk_div=1, LANES=1, MSB_FIRST=1: send 0xA5 with MISO looped to MOSI -> 8 SCK periods of 4 clk; m_axis=0xA5; csn low exactly CS_SETUP+16 half-periods+CS_HOLD; frame_bytes=1.
- Sweep all 4 cpol/cpha modes, send 0x3C with a slave model -> sample/shift edges match mode; SCK idles at cpol; rx=0x3C in each mode.
- LANES=4, send 0x12,0x34 back-to-back -> 2 SCK periods per byte, csn continuous, m_axis 0x12 then 0x34.
- m_axis_tready=0 for 50 cycles while sending 3 bytes -> SCK stops after byte 2 (STALL); no edges; all 3 bytes delivered in order after tready.
- enable=1 with source empty for 4 bytes -> MOSI all 0x00, 4 RX bytes forwarded; drop enable -> csn rises after current byte + CS_HOLD.
- Assert resn mid-byte -> spi_csn all 1, spi_clk 0, m_axis_tvalid 0 asynchronously; next frame uses new cs_sel=1 and runs cleanly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master to AXI-Stream bridge.
package spi_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        LOAD,
        SHIFT,
        STALL,
        CS_HOLD,
        CS_GAP
    } spi_state_e;

    function automatic int bits_per_byte(input int lanes);
        return 8 / lanes;
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period divider and SCK register. While not shifting, SCK sits at the
// idle level; while shifting, every terminal count toggles it.
module spi_sck_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             resn,
    input  logic             run,
    input  logic             shift,
    input  logic [DIV_W-1:0] div,
    input  logic             idle_lvl,
    output logic             tick,
    output logic             lead,
    output logic             trail,
    output logic             sck
);

    logic [DIV_W-1:0] cnt;
    logic             phase;

    assign tick  = run && (cnt == div);
    assign lead  = shift && tick && !phase;
    assign trail = shift && tick && phase;

    // Counter rests at zero whenever not running, so every timed state starts fresh.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            cnt   <= '0;
            phase <= 1'b0;
            sck   <= 1'b0;
        end else begin
            if (!run || tick) cnt <= '0;
            else              cnt <= cnt + DIV_W'(1);

            if (!shift) begin
                phase <= 1'b0;
                sck   <= idle_lvl;
            end else if (tick) begin
                phase <= ~phase;
                sck   <= ~sck;
            end
        end
    end

endmodule

// File: rtl/spi_axis_if_v2.sv
// SPI master with runtime mode, 1/2/4 lanes and multiple chip selects,
// bridging an AXIS byte source (MOSI) and an AXIS byte sink (MISO).
module spi_axis_if_v2
    import spi_pkg::*;
#(
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 0,
    parameter int DIV_W     = 8,
    parameter int N_CS      = 1,
    localparam int CS_W     = (N_CS > 1) ? $clog2(N_CS) : 1
) (
    input  logic             clk,
    input  logic             resn,
    input  logic             enable,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [CS_W-1:0]  cs_sel,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [N_CS-1:0]  spi_csn,
    output logic             spi_clk,
    output logic [LANES-1:0] spi_mosi,
    input  logic [LANES-1:0] spi_miso,
    output logic             busy,
    output logic [15:0]      frame_bytes
);

    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_lanes_chk
        $error("spi_axis_if_v2: LANES must be 1, 2 or 4");
    end

    localparam int             BPB    = bits_per_byte(LANES);
    localparam logic [N_CS-1:0] CS_ONE = N_CS'(1);

    spi_state_e       state;
    logic             cpol_q, cpha_q;
    logic [DIV_W-1:0] div_q;
    byte_t            tx_sr, rx_sr, hold_q, rx_shift, tx_next, rx_cur;
    logic [2:0]       trail_cnt;
    logic             tick, lead, trail, start, run, in_shift, idle_lvl;
    logic             sample, shift_out, done;

    assign start    = (state == IDLE) && (s_axis_tvalid || enable);
    assign run      = (state == CS_SETUP) || (state == SHIFT) ||
                      (state == CS_HOLD)  || (state == CS_GAP);
    assign in_shift = (state == SHIFT);
    // New cpol reaches SCK on the same edge that drops csn.
    assign idle_lvl = start ? cpol : cpol_q;

    assign busy          = (state != IDLE);
    assign s_axis_tready = (state == LOAD) && s_axis_tvalid;

    if (MSB_FIRST != 0) begin : g_msb
        assign spi_mosi = tx_sr[7 -: LANES];
        assign rx_shift = {rx_sr[7-LANES:0], spi_miso};
        assign tx_next  = tx_sr << LANES;
    end else begin : g_lsb
        assign spi_mosi = tx_sr[LANES-1:0];
        assign rx_shift = {spi_miso, rx_sr[7:LANES]};
        assign tx_next  = tx_sr >> LANES;
    end

    // cpha=1 keeps the first group on MOSI through the first leading edge.
    assign sample    = cpha_q ? trail : lead;
    assign shift_out = cpha_q ? (lead && trail_cnt != 3'd0) : trail;
    assign done      = trail && (trail_cnt == 3'(BPB - 1));
    assign rx_cur    = sample ? rx_shift : rx_sr;

    spi_sck_gen #(.DIV_W(DIV_W)) u_sck (
        .clk      (clk),
        .resn     (resn),
        .run      (run),
        .shift    (in_shift),
        .div      (div_q),
        .idle_lvl (idle_lvl),
        .tick     (tick),
        .lead     (lead),
        .trail    (trail),
        .sck      (spi_clk)
    );

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state         <= IDLE;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            div_q         <= '0;
            spi_csn       <= '1;
            tx_sr         <= '0;
            rx_sr         <= '0;
            hold_q        <= '0;
            trail_cnt     <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            frame_bytes   <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

            case (state)
                IDLE: if (start) begin
                    cpol_q      <= cpol;
                    cpha_q      <= cpha;
                    div_q       <= clk_div;
                    spi_csn     <= ~(CS_ONE << cs_sel);
                    frame_bytes <= '0;
                    state       <= CS_SETUP;
                end
                CS_SETUP: if (tick) state <= LOAD;
                LOAD: begin
                    trail_cnt <= '0;
                    if (s_axis_tvalid) begin
                        tx_sr <= s_axis_tdata;
                        state <= SHIFT;
                    end else if (enable) begin
                        tx_sr <= '0;
                        state <= SHIFT;
                    end else begin
                        tx_sr <= '0;
                        state <= CS_HOLD;
                    end
                end
                SHIFT: begin
                    if (sample)    rx_sr     <= rx_shift;
                    if (shift_out) tx_sr     <= tx_next;
                    if (trail)     trail_cnt <= trail_cnt + 3'd1;
                    if (done) begin
                        if (frame_bytes != 16'hFFFF) frame_bytes <= frame_bytes + 16'd1;
                        if (m_axis_tvalid && !m_axis_tready) begin
                            hold_q <= rx_cur;
                            state  <= STALL;
                        end else begin
                            m_axis_tdata  <= rx_cur;
                            m_axis_tvalid <= 1'b1;
                            state         <= LOAD;
                        end
                    end
                end
                STALL: if (m_axis_tready) begin
                    m_axis_tdata  <= hold_q;
                    m_axis_tvalid <= 1'b1;
                    state         <= LOAD;
                end
                CS_HOLD: if (tick) begin
                    spi_csn <= '1;
                    state   <= CS_GAP;
                end
                CS_GAP: if (tick) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_axis_if_v2.sv
// Directed bench: a 1-lane MSB-first instance with two chip selects and a
// 4-lane LSB-first instance, both with MISO looped back to MOSI.
module tb_spi_axis_if_v2;

    logic       clk = 1'b0;
    logic       resn = 1'b0;
    logic [7:0] clk_div = 8'd1;
    logic       cpol = 1'b0, cpha = 1'b0;
    always #5 clk = ~clk;

    logic       en1 = 1'b0, tvalid1 = 1'b0, mready1 = 1'b1;
    logic [0:0] cs_sel1 = 1'b0;
    logic [7:0] tdata1 = 8'h00, mdata1;
    logic       tready1, mvalid1, sck1, busy1;
    logic [1:0] csn1;
    logic [0:0] mosi1;
    logic [15:0] fb1;

    logic       en4 = 1'b0, tvalid4 = 1'b0, mready4 = 1'b1;
    logic [0:0] cs_sel4 = 1'b0;
    logic [7:0] tdata4 = 8'h00, mdata4;
    logic       tready4, mvalid4, sck4, busy4;
    logic [0:0] csn4;
    logic [3:0] mosi4;
    logic [15:0] fb4;

    spi_axis_if_v2 #(.LANES(1), .MSB_FIRST(1), .DIV_W(8), .N_CS(2)) u_dut1 (
        .clk(clk), .resn(resn), .enable(en1), .clk_div(clk_div), .cpol(cpol), .cpha(cpha),
        .cs_sel(cs_sel1), .s_axis_tdata(tdata1), .s_axis_tvalid(tvalid1), .s_axis_tready(tready1),
        .m_axis_tdata(mdata1), .m_axis_tvalid(mvalid1), .m_axis_tready(mready1),
        .spi_csn(csn1), .spi_clk(sck1), .spi_mosi(mosi1), .spi_miso(mosi1),
        .busy(busy1), .frame_bytes(fb1));

    spi_axis_if_v2 #(.LANES(4), .MSB_FIRST(0), .DIV_W(8), .N_CS(1)) u_dut4 (
        .clk(clk), .resn(resn), .enable(en4), .clk_div(clk_div), .cpol(cpol), .cpha(cpha),
        .cs_sel(cs_sel4), .s_axis_tdata(tdata4), .s_axis_tvalid(tvalid4), .s_axis_tready(tready4),
        .m_axis_tdata(mdata4), .m_axis_tvalid(mvalid4), .m_axis_tready(mready4),
        .spi_csn(csn4), .spi_clk(sck4), .spi_mosi(mosi4), .spi_miso(mosi4),
        .busy(busy4), .frame_bytes(fb4));

    // Slave-side observers; SCK activity only counts while csn was already low.
    int         cyc = 0;
    logic       sck1_prev = 1'b0, sel1_prev = 1'b0, sck4_prev = 1'b0, sel4_prev = 1'b0;
    logic       csn4_prev = 1'b1;
    int         edges1 = 0, rise1_t = 0, rise1_prev = 0, low1 = 0, rx1_n = 0;
    int         rise4 = 0, low4 = 0, csnr4 = 0, rx4_n = 0;
    logic [7:0] cap1 = 8'h00, cap4 = 8'h00;
    logic [7:0] rx1_log [256];
    logic [7:0] rx4_log [256];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (csn1 != 2'b11 && sel1_prev && sck1 != sck1_prev) begin
            edges1 <= edges1 + 1;
            if (sck1 && !sck1_prev) begin
                rise1_prev <= rise1_t;
                rise1_t    <= cyc;
            end
            if ((sck1 != cpol) != cpha) cap1 <= {cap1[6:0], mosi1[0]};
        end
        sck1_prev <= sck1;
        sel1_prev <= (csn1 != 2'b11);
        if (csn1 != 2'b11) low1 <= low1 + 1;
        if (mvalid1 && mready1) begin
            rx1_log[rx1_n[7:0]] <= mdata1;
            rx1_n <= rx1_n + 1;
        end

        if (!csn4[0] && sel4_prev && sck4 && !sck4_prev) begin
            rise4 <= rise4 + 1;
            cap4  <= {mosi4, cap4[7:4]};
        end
        sck4_prev <= sck4;
        sel4_prev <= !csn4[0];
        csn4_prev <= csn4[0];
        if (csn4[0] && !csn4_prev) csnr4 <= csnr4 + 1;
        if (!csn4[0]) low4 <= low4 + 1;
        if (mvalid4 && mready4) begin
            rx4_log[rx4_n[7:0]] <= mdata4;
            rx4_n <= rx4_n + 1;
        end
    end

    int pass_cnt = 0, total_cnt = 0, fail_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push1(input logic [7:0] b);
        tdata1  = b;
        tvalid1 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tready1) break;
        end
        check("push1 accept", 32'(tready1), 32'd1);
        @(posedge clk); #1;
        tvalid1 = 1'b0;
    endtask

    task automatic push4(input logic [7:0] b);
        tdata4  = b;
        tvalid4 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tready4) break;
        end
        check("push4 accept", 32'(tready4), 32'd1);
        @(posedge clk); #1;
        tvalid4 = 1'b0;
    endtask

    task automatic wait_idle1(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy1) break;
        end
        check(tag, 32'(busy1), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle4(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy4) break;
        end
        check(tag, 32'(busy4), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int base, l0, e0, r0, c0;
        logic [7:0] acc;

        repeat (3) @(negedge clk);
        check("rst csn",    32'(csn1),    32'h3);
        check("rst sck",    32'(sck1),    32'd0);
        check("rst mosi",   32'(mosi1),   32'd0);
        check("rst tready", 32'(tready1), 32'd0);
        check("rst mvalid", 32'(mvalid1), 32'd0);
        check("rst mdata",  32'(mdata1),  32'd0);
        check("rst busy",   32'(busy1),   32'd0);
        check("rst fbytes", 32'(fb1),     32'd0);
        @(posedge clk); #1;
        resn = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 0, 1 lane: csn low = setup 2 + load 1 + shift 32 + load 1 + hold 2.
        base = rx1_n; l0 = low1; e0 = edges1;
        push1(8'hA5);
        wait_idle1("t1 idle");
        check("t1 rx",      32'(rx1_log[base]), 32'hA5);
        check("t1 nrx",     32'(rx1_n - base),  32'd1);
        check("t1 slave",   32'(cap1),          32'hA5);
        check("t1 csn low", 32'(low1 - l0),     32'd38);
        check("t1 edges",   32'(edges1 - e0),   32'd16);
        check("t1 period",  32'(rise1_t - rise1_prev), 32'd4);
        check("t1 fbytes",  32'(fb1),           32'd1);
        check("t1 csn end", 32'(csn1),          32'h3);

        for (int m = 0; m < 4; m++) begin
            @(posedge clk); #1;
            cpol = m[1];
            cpha = m[0];
            e0 = edges1;
            push1(8'h3C);
            wait_idle1($sformatf("mode%0d idle", m));
            check($sformatf("mode%0d rx", m),    32'(rx1_log[rx1_n - 1]), 32'h3C);
            check($sformatf("mode%0d slave", m), 32'(cap1),               32'h3C);
            check($sformatf("mode%0d sck", m),   32'(sck1),               32'(cpol));
            check($sformatf("mode%0d edges", m), 32'(edges1 - e0),        32'd16);
        end
        @(posedge clk); #1;
        cpol = 1'b0;
        cpha = 1'b0;

        // 4 lanes: setup 2 + 2*(load 1 + shift 8) + load 1 + hold 2 = 23.
        base = rx4_n; l0 = low4; r0 = rise4; c0 = csnr4;
        push4(8'h12);
        push4(8'h34);
        wait_idle4("l4 idle");
        check("l4 rx0",     32'(rx4_log[base]),     32'h12);
        check("l4 rx1",     32'(rx4_log[base + 1]), 32'h34);
        check("l4 slave",   32'(cap4),              32'h34);
        check("l4 rises",   32'(rise4 - r0),        32'd4);
        check("l4 csn low", 32'(low4 - l0),         32'd23);
        check("l4 csn rise",32'(csnr4 - c0),        32'd1);
        check("l4 fbytes",  32'(fb4),               32'd2);

        // Sink back-pressure: byte 2 finds byte 1 still pending and stalls.
        base = rx1_n;
        mready1 = 1'b0;
        push1(8'hA1);
        push1(8'hB2);
        tdata1  = 8'hC4;
        tvalid1 = 1'b1;
        repeat (40) @(negedge clk);
        e0 = edges1;
        repeat (50) @(negedge clk);
        check("stall edges",  32'(edges1 - e0), 32'd0);
        check("stall mvalid", 32'(mvalid1),     32'd1);
        check("stall mdata",  32'(mdata1),      32'hA1);
        check("stall tready", 32'(tready1),     32'd0);
        check("stall busy",   32'(busy1),       32'd1);
        @(posedge clk); #1;
        mready1 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tready1) break;
        end
        check("stall c accept", 32'(tready1), 32'd1);
        @(posedge clk); #1;
        tvalid1 = 1'b0;
        wait_idle1("stall idle");
        check("stall nrx", 32'(rx1_n - base),       32'd3);
        check("stall rx0", 32'(rx1_log[base]),      32'hA1);
        check("stall rx1", 32'(rx1_log[base + 1]),  32'hB2);
        check("stall rx2", 32'(rx1_log[base + 2]),  32'hC4);

        // Dummy bytes: enable drops while byte 5 has just been loaded.
        // csn low = setup 2 + 5*(1+32) + load 1 + hold 2 = 170.
        base = rx1_n; l0 = low1;
        @(posedge clk); #1;
        en1 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (fb1 == 16'd4) break;
        end
        check("en fb4", 32'(fb1), 32'd4);
        @(posedge clk); #1;
        en1 = 1'b0;
        wait_idle1("en idle");
        acc = 8'h00;
        for (int i = 0; i < 5; i++) acc = acc | rx1_log[base + i];
        check("en fbytes",  32'(fb1),          32'd5);
        check("en nrx",     32'(rx1_n - base), 32'd5);
        check("en rx zero", 32'(acc),          32'd0);
        check("en slave",   32'(cap1),         32'd0);
        check("en csn low", 32'(low1 - l0),    32'd170);

        // Abort mid-byte with cpol=1 so the forced SCK=0 is visible.
        @(posedge clk); #1;
        cpol = 1'b1;
        cpha = 1'b1;
        mready1 = 1'b0;
        en1 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mvalid1) break;
        end
        check("rst2 first byte", 32'(mvalid1), 32'd1);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        resn = 1'b0;
        #1;
        check("rst2 csn",    32'(csn1),    32'h3);
        check("rst2 sck",    32'(sck1),    32'd0);
        check("rst2 mvalid", 32'(mvalid1), 32'd0);
        check("rst2 busy",   32'(busy1),   32'd0);
        check("rst2 fbytes", 32'(fb1),     32'd0);
        en1 = 1'b0;
        mready1 = 1'b1;
        cpol = 1'b0;
        cpha = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resn = 1'b1;
        cs_sel1 = 1'b1;
        push1(8'hC3);
        check("cs1 csn", 32'(csn1), 32'h1);
        wait_idle1("cs1 idle");
        check("cs1 rx",     32'(rx1_log[rx1_n - 1]), 32'hC3);
        check("cs1 slave",  32'(cap1),               32'hC3);
        check("cs1 fbytes", 32'(fb1),                32'd1);
        check("cs1 csn end",32'(csn1),               32'h3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
